// File: rtl/swd_xact_if.sv
// Host-side request/response and engine-side configuration/result signals of swd_xact.
// The slave modport is the sequencer's view; master is the host plus bit engine.
interface swd_xact_if;
    logic        go;
    logic        apndp;
    logic        rnw;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [2:0]  ack;
    logic [31:0] rdata;
    logic        perr;
    logic [4:0]  eng_bits;
    logic        eng_par;
    logic        eng_txreq;
    logic        eng_rxreq;
    logic [31:0] eng_wdata;
    logic [31:0] eng_rdata;
    logic        eng_pgood;
    logic        eng_busy;

    modport master (
        output go, apndp, rnw, addr, wdata, eng_rdata, eng_pgood, eng_busy,
        input  busy, done, ack, rdata, perr, eng_bits, eng_par, eng_txreq, eng_rxreq, eng_wdata
    );

    modport slave (
        input  go, apndp, rnw, addr, wdata, eng_rdata, eng_pgood, eng_busy,
        output busy, done, ack, rdata, perr, eng_bits, eng_par, eng_txreq, eng_rxreq, eng_wdata
    );
endinterface

// File: rtl/swd_xact.sv
// SWD transaction sequencer: turns one host request into header, ACK, data+parity and
// trailing idle operations on the bit engine, retrying on WAIT.
module swd_xact #(
    parameter int unsigned RETRIES     = 8,
    parameter int unsigned IDLE_BITS   = 8,
    parameter int unsigned REQ_GAP     = 16,
    parameter int unsigned REQ_TIMEOUT = 64
) (
    input logic       clk,
    input logic       rst,
    swd_xact_if.slave bus
);
    localparam int unsigned RW   = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
    localparam int unsigned CMAX = (REQ_GAP > REQ_TIMEOUT) ? REQ_GAP : REQ_TIMEOUT;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {StIdle, StHdr, StAck, StRdata, StWdata, StTrail, StDone} mainSt_t;
    // PhLoad presents the operation's configuration and raises its request.
    typedef enum logic [1:0] {PhLoad, PhReq, PhAct, PhGap} phase_t;

    mainSt_t        mainSt;
    mainSt_t        nextSt;
    phase_t         phase;
    logic [CW-1:0]  cnt;
    logic [RW-1:0]  retryCnt;
    logic           retry;
    logic           apndpQ;
    logic           rnwQ;
    logic [1:0]     addrQ;
    logic [31:0]    wdataQ;
    logic [2:0]     ackRes;
    logic [31:0]    rdBuf;
    logic           pBuf;
    logic [7:0]     header;
    logic           cfgTx;
    logic [4:0]     cfgBits;
    logic           cfgPar;
    logic [31:0]    cfgWord;

    // Request header, sent LSB first: start, APnDP, RnW, A2, A3, parity, stop, park.
    assign header = {1'b1, 1'b0, apndpQ ^ rnwQ ^ addrQ[0] ^ addrQ[1],
                     addrQ[1], addrQ[0], rnwQ, apndpQ, 1'b1};

    // Engine configuration for the operation belonging to the current main state.
    always_comb begin
        cfgTx   = 1'b1;
        cfgBits = 5'd0;
        cfgPar  = 1'b0;
        cfgWord = 32'd0;
        unique case (mainSt)
            StHdr: begin
                cfgBits = 5'd7;
                cfgWord = {24'd0, header};
            end
            StAck: begin
                cfgTx   = 1'b0;
                cfgBits = 5'd2;
            end
            StRdata: begin
                cfgTx   = 1'b0;
                cfgBits = 5'd31;
                cfgPar  = 1'b1;
            end
            StWdata: begin
                cfgBits = 5'd31;
                cfgPar  = 1'b1;
                cfgWord = wdataQ;
            end
            StTrail: cfgBits = 5'(IDLE_BITS - 1);
            default: ;
        endcase
    end

    // Main sequencer and per-operation REQ/ACT/GAP handshake, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            mainSt        <= StIdle;
            nextSt        <= StIdle;
            phase         <= PhLoad;
            cnt           <= '0;
            retryCnt      <= '0;
            retry         <= 1'b0;
            apndpQ        <= 1'b0;
            rnwQ          <= 1'b0;
            addrQ         <= 2'd0;
            wdataQ        <= 32'd0;
            ackRes        <= 3'd0;
            rdBuf         <= 32'd0;
            pBuf          <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.ack       <= 3'd0;
            bus.rdata     <= 32'd0;
            bus.perr      <= 1'b0;
            bus.eng_bits  <= 5'd0;
            bus.eng_par   <= 1'b0;
            bus.eng_txreq <= 1'b0;
            bus.eng_rxreq <= 1'b0;
            bus.eng_wdata <= 32'd0;
        end else begin
            bus.done <= 1'b0;
            unique case (mainSt)
                StIdle: begin
                    // A go coinciding with the done pulse is dropped.
                    if (bus.go && !bus.done) begin
                        apndpQ   <= bus.apndp;
                        rnwQ     <= bus.rnw;
                        addrQ    <= bus.addr;
                        wdataQ   <= bus.wdata;
                        retryCnt <= '0;
                        retry    <= 1'b0;
                        bus.busy <= 1'b1;
                        mainSt   <= StHdr;
                        phase    <= PhLoad;
                    end
                end
                StDone: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    bus.ack  <= ackRes;
                    // Read results are only committed for a completed OK read.
                    if (ackRes == 3'b001 && rnwQ) begin
                        bus.rdata <= rdBuf;
                        bus.perr  <= pBuf;
                    end else begin
                        bus.perr  <= 1'b0;
                    end
                    mainSt <= StIdle;
                end
                default: begin
                    unique case (phase)
                        PhLoad: begin
                            bus.eng_bits  <= cfgBits;
                            bus.eng_par   <= cfgPar;
                            bus.eng_wdata <= cfgWord;
                            bus.eng_txreq <= cfgTx;
                            bus.eng_rxreq <= !cfgTx;
                            cnt           <= '0;
                            phase         <= PhReq;
                        end
                        PhReq: begin
                            if (bus.eng_busy) begin
                                bus.eng_txreq <= 1'b0;
                                bus.eng_rxreq <= 1'b0;
                                phase         <= PhAct;
                            end else if (cnt == CW'(REQ_TIMEOUT - 1)) begin
                                bus.eng_txreq <= 1'b0;
                                bus.eng_rxreq <= 1'b0;
                                ackRes        <= 3'b111;
                                mainSt        <= StDone;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        PhAct: begin
                            if (!bus.eng_busy) begin
                                cnt   <= '0;
                                phase <= PhGap;
                                unique case (mainSt)
                                    StHdr: nextSt <= StAck;
                                    StAck: begin
                                        ackRes <= bus.eng_rdata[2:0];
                                        if (bus.eng_rdata[2:0] == 3'b001) begin
                                            retry  <= 1'b0;
                                            nextSt <= rnwQ ? StRdata : StWdata;
                                        end else if (bus.eng_rdata[2:0] == 3'b010 &&
                                                     32'(retryCnt) < RETRIES) begin
                                            retryCnt <= retryCnt + RW'(1);
                                            retry    <= 1'b1;
                                            nextSt   <= StTrail;
                                        end else begin
                                            retry  <= 1'b0;
                                            nextSt <= StTrail;
                                        end
                                    end
                                    StRdata: begin
                                        rdBuf  <= bus.eng_rdata;
                                        pBuf   <= !bus.eng_pgood;
                                        nextSt <= StTrail;
                                    end
                                    StWdata: nextSt <= StTrail;
                                    StTrail: nextSt <= retry ? StHdr : StDone;
                                    default: nextSt <= StDone;
                                endcase
                            end
                        end
                        PhGap: begin
                            // Both requests stay low so the engine's edge detector re-arms.
                            if (cnt == CW'(REQ_GAP - 1)) begin
                                mainSt <= nextSt;
                                phase  <= PhLoad;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    endcase
                end
            endcase
        end
    end
endmodule

// File: doc/swd_xact.md
# swd_xact

Transaction sequencer for the SWD bit engine. Converts one host request (AP/DP, read/write, A[3:2], write data) into the full SWD packet: 8-bit header, ACK read, 32-bit data plus parity, and trailing idle clocks. Automatic retry on WAIT. Sits between the host command path and the bit engine, and is the only driver of the engine's request and configuration inputs.

## Interface
- RETRIES, 8: maximum re-issues after a WAIT ACK before giving up (0 = never retry).
- IDLE_BITS, 8: trailing zero bits clocked after every packet (1..32).
- REQ_GAP, 16: clk cycles both engine requests are held low between engine operations.
- REQ_TIMEOUT, 64: clk cycles allowed for the engine's busy to rise after a request is raised.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- go  in  1  single-cycle start pulse; ignored while busy.
- apndp  in  1  0 = DP, 1 = AP; sampled on go.
- rnw  in  1  1 = read, 0 = write; sampled on go.
- addr  in  2  A[3:2]; sampled on go.
- wdata  in  32  write data; sampled on go.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at end of transaction.
- ack  out  3  final ACK (001 OK, 010 WAIT, 100 FAULT, 111 timeout/no response); valid from done until next go.
- rdata  out  32  read data; valid with done when ack = 001 and rnw = 1.
- perr  out  1  read parity mismatch; valid with done.
- eng_bits  out  5  engine bit count minus 1.
- eng_par  out  1  engine parity enable.
- eng_txreq  out  1  engine transmit request (level).
- eng_rxreq  out  1  engine receive request (level).
- eng_wdata  out  32  engine transmit word.
- eng_rdata  in  32  engine received word.
- eng_pgood  in  1  engine parity good.
- eng_busy  in  1  engine busy.

## Operation
- Reset: busy = 0, done = 0, ack = 000, rdata = 0, perr = 0, eng_txreq = 0, eng_rxreq = 0, eng_bits = 0, eng_par = 0, eng_wdata = 0. State returns to IDLE. A reset mid-operation abandons the transaction with no done pulse.
- Header byte, LSB first: {park=1, stop=0, par, A3, A2, RnW, APnDP, start=1}, where par = APnDP^RnW^A2^A3.
- Main states:
  - IDLE: on go, latch the inputs and clear retry_cnt. Then go to HDR.
  - HDR: tx, bits = 7, par = 0, word = header. Then ACK.
  - ACK: rx, bits = 2, par = 0. ack_i = eng_rdata[2:0].
    - If ack_i = 001: go to RDATA if rnw, else WDATA.
    - If ack_i = 010 and retry_cnt < RETRIES: increment retry_cnt, go to TRAIL, then re-enter HDR.
    - Any other value: go to TRAIL and finish.
  - RDATA: rx, bits = 31, par = 1. Latch rdata = eng_rdata and perr = !eng_pgood. Then TRAIL.
  - WDATA: tx, bits = 31, par = 1, word = wdata. Then TRAIL.
  - TRAIL: tx, bits = IDLE_BITS-1, par = 0, word = 0. Then DONE or HDR (retry).
  - DONE: drive ack, pulse done, return to IDLE.
- Each engine operation runs the sub-sequence REQ → ACT → GAP:
  - REQ: drive eng_bits, eng_par and eng_wdata, and raise the selected request. Hold all of these until eng_busy = 1.
  - ACT: drop the request and wait for eng_busy = 0. Capture results on the cycle eng_busy falls.
  - GAP: both requests low for REQ_GAP cycles. This lets the engine's request edge detector re-arm.
- Timeout: if eng_busy does not rise within REQ_TIMEOUT cycles of REQ, set ack = 111, drop the request, and go straight to DONE. TRAIL is skipped.
- Turnaround cycles are inserted by the engine on direction change. The sequencer does not count them.
- eng_txreq and eng_rxreq are never high at the same time.

## Timing
- go → busy = 1 on the next cycle. busy falls on the cycle done pulses.
- Total latency is engine-paced; each engine operation adds at least REQ_GAP cycles.
- eng_* configuration outputs are stable from REQ entry until eng_busy rises.
- go while busy = 1 is dropped. go on the done cycle is dropped. go in the cycle after done is accepted.
- Retry counter width is clog2(RETRIES+1). WAIT with retry_cnt = RETRIES finishes with ack = 010.
- perr is forced to 0 for writes and for non-OK ACKs. rdata holds its previous value unless a read completes with ACK OK.

## Test plan
- DP read, addr 0 (IDCODE): engine model returns ACK 001 and 0x2BA01477 with good parity → header tx 0xA5 with bits = 7, rdata = 0x2BA01477, ack = 001, perr = 0, done pulses exactly once.
- DP write, addr 1, wdata 0x50000000 → header 0xA9; tx ops in order: bits = 7, then rx bits = 2, then tx bits = 31 par = 1 with word 0x50000000, then tx IDLE_BITS zeros; ack = 001.
- WAIT ×3 then OK with RETRIES = 8 → 4 headers sent, each WAIT followed by a TRAIL; final ack = 001. Separately, WAIT forever with RETRIES = 2 → 3 headers, ack = 010.
- FAULT on ACK for a read → no RDATA operation; TRAIL runs; ack = 100; rdata unchanged.
- Parity error (eng_pgood = 0) on a read → perr = 1, ack = 001. Engine never asserts busy → done after REQ_TIMEOUT with ack = 111. Reset asserted during RDATA → all outputs at reset values next cycle, no done pulse.
- Back-to-back: go on the done cycle is ignored; go one cycle later starts a new header. Requests stay low for REQ_GAP cycles between every engine operation.
